// File: rtl/shared_adder_sched.sv
// rtl/shared_adder_sched.sv - round-robin sequencer sharing one external ripple adder
//
// Grants a single external W-bit adder to one of NREQ requesters at a time.
// Narrow ops take one adder pass (LOW). Wide ops take two passes (LOW then
// HIGH), with the low-half carry held in a register between them.
//
// Optional feature macro: SHARED_ADDER_OVF_EN. When defined, a registered
// signed-overflow flag is computed on the final half. When undefined, ovf is
// tied to 0.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req[NREQ]         per-requester request, held until own done
//   wide[NREQ]        1 = 2W-bit op, 0 = W-bit op
//   op_a, op_b        2W-bit operands per requester, packed [2W*i +: 2W]
//   op_cin[NREQ]      carry-in per requester
//   gnt[NREQ]         one-hot grant, LOW through DONE
//   done[NREQ]        one-cycle completion pulse
//   result, result_cout, ovf   registered result of the last completed op
//   add_a, add_b, add_cin      drive the shared adder
//   add_sum, add_cout          combinational return from the shared adder
module shared_adder_sched #(
  parameter int NREQ = 2,
  parameter int W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       wide,
  input  logic [2*W*NREQ-1:0]   op_a,
  input  logic [2*W*NREQ-1:0]   op_b,
  input  logic [NREQ-1:0]       op_cin,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [2*W-1:0]        result,
  output logic                  result_cout,
  output logic                  ovf,
  output logic [W-1:0]          add_a,
  output logic [W-1:0]          add_b,
  output logic                  add_cin,
  input  logic [W-1:0]          add_sum,
  input  logic                  add_cout
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   idx;
  logic [2*W-1:0]  a_q, b_q;
  logic            cin_q, wide_q, carry_q;

  logic            any_req;
  logic [IW-1:0]   pick_idx;
  int              j;

  // First set request scanning upward from ptr, wrapping modulo NREQ.
  always_comb begin
    any_req  = 1'b0;
    pick_idx = '0;
    j        = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any_req && req[j]) begin
        any_req  = 1'b1;
        pick_idx = IW'(j);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = LOW;
      LOW:     state_nxt = wide_q ? HIGH : DONE;
      HIGH:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    gnt     = '0;
    done    = '0;
    case (state)
      LOW: begin
        add_a   = a_q[W-1:0];
        add_b   = b_q[W-1:0];
        add_cin = cin_q;
      end
      HIGH: begin
        add_a   = a_q[2*W-1:W];
        add_b   = b_q[2*W-1:W];
        add_cin = carry_q;
      end
      default: ;
    endcase
    if (state != IDLE) gnt[idx] = 1'b1;
    if (state == DONE) done[idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      idx         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      wide_q      <= 1'b0;
      carry_q     <= 1'b0;
      result      <= '0;
      result_cout <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (any_req) begin
            idx    <= pick_idx;
            a_q    <= op_a[int'(pick_idx)*2*W +: 2*W];
            b_q    <= op_b[int'(pick_idx)*2*W +: 2*W];
            cin_q  <= op_cin[pick_idx];
            wide_q <= wide[pick_idx];
          end
        end
        LOW: begin
          result[W-1:0] <= add_sum;
          carry_q       <= add_cout;
          if (!wide_q) begin
            result[2*W-1:W] <= '0;
            result_cout     <= add_cout;
          end
        end
        HIGH: begin
          result[2*W-1:W] <= add_sum;
          result_cout     <= add_cout;
        end
        DONE: begin
          ptr <= (idx == IW'(NREQ-1)) ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SHARED_ADDER_OVF_EN
  logic ovf_calc;

  // Signed overflow of whichever half the adder is working on this cycle.
  always_comb begin
    ovf_calc = (add_a[W-1] == add_b[W-1]) && (add_sum[W-1] != add_a[W-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if ((state == LOW && !wide_q) || state == HIGH) begin
      ovf <= ovf_calc;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_shared_adder_sched.sv
// tb/tb_shared_adder_sched.sv - scoreboard bench for shared_adder_sched
module tb_shared_adder_sched;

  localparam int NREQ = 2;
  localparam int W    = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ-1:0]      wide = '0;
  logic [2*W*NREQ-1:0]  op_a = '0;
  logic [2*W*NREQ-1:0]  op_b = '0;
  logic [NREQ-1:0]      op_cin = '0;
  logic [NREQ-1:0]      gnt, done;
  logic [2*W-1:0]       result;
  logic                 result_cout, ovf;
  logic [W-1:0]         add_a, add_b, add_sum;
  logic                 add_cin, add_cout;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] res;
    logic        cout;
    logic        ovf;
    int          idx;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  // External 16-bit ripple adder stand-in.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + 17'(add_cin);

  shared_adder_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wide(wide), .op_a(op_a), .op_b(op_b),
    .op_cin(op_cin), .gnt(gnt), .done(done), .result(result),
    .result_cout(result_cout), .ovf(ovf), .add_a(add_a), .add_b(add_b),
    .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int i, input bit wd, input logic [31:0] a,
                                 input logic [31:0] b, input bit c);
    exp_t        e;
    logic [32:0] s;
    logic [16:0] sl;
    e.idx = i;
    if (wd) begin
      s      = {1'b0, a} + {1'b0, b} + 33'(c);
      e.res  = s[31:0];
      e.cout = s[32];
      e.ovf  = (a[31] == b[31]) && (s[31] != a[31]);
    end else begin
      sl     = {1'b0, a[15:0]} + {1'b0, b[15:0]} + 17'(c);
      e.res  = {16'h0, sl[15:0]};
      e.cout = sl[16];
      e.ovf  = (a[15] == b[15]) && (sl[15] != a[15]);
    end
`ifndef SHARED_ADDER_OVF_EN
    e.ovf = 1'b0;
`endif
    return e;
  endfunction

  // Output monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("gnt_multi_hot", 64'($countones(gnt) > 1), 64'd0);
      if (done != '0) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("done_idx", 64'(done), 64'(NREQ'(1) << e.idx));
          chk("result", 64'(result), 64'(e.res));
          chk("result_cout", 64'(result_cout), 64'(e.cout));
          chk("ovf", 64'(ovf), 64'(e.ovf));
        end
      end
    end
  end

  // Single op on requester i, with latency and adder-port checks.
  task automatic do_op(input int i, input bit wd, input logic [31:0] a,
                       input logic [31:0] b, input bit c);
    int          cnt;
    logic [16:0] lo;
    lo = {1'b0, a[15:0]} + {1'b0, b[15:0]} + 17'(c);
    @(negedge clk);
    op_a[32*i +: 32] = a;
    op_b[32*i +: 32] = b;
    op_cin[i] = c;
    wide[i]   = wd;
    req[i]    = 1'b1;
    sbq.push_back(model(i, wd, a, b, c));
    @(negedge clk);
    cnt = 1;
    chk("gnt", 64'(gnt), 64'(NREQ'(1) << i));
    chk("low_add_a", 64'(add_a), 64'(a[15:0]));
    chk("low_add_b", 64'(add_b), 64'(b[15:0]));
    chk("low_add_cin", 64'(add_cin), 64'(c));
    // Operands are latched at grant; disturbing them must not matter.
    op_a[32*i +: 32] = $urandom;
    op_b[32*i +: 32] = $urandom;
    op_cin[i] = ~c;
    if (wd) begin
      @(negedge clk);
      cnt = 2;
      chk("high_add_a", 64'(add_a), 64'(a[31:16]));
      chk("high_add_b", 64'(add_b), 64'(b[31:16]));
      chk("high_add_cin", 64'(add_cin), 64'(lo[16]));
    end
    while (done[i] !== 1'b1 && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk(wd ? "wide_latency" : "narrow_latency", 64'(cnt), wd ? 64'd3 : 64'd2);
    req[i] = 1'b0;
  endtask

  // Both requesters raised together; expect requester 0 first.
  task automatic pair(input logic [31:0] a0, input logic [31:0] b0,
                      input logic [31:0] a1, input logic [31:0] b1);
    logic [1:0] seen;
    int         cnt;
    @(negedge clk);
    op_a = {a1, a0};
    op_b = {b1, b0};
    op_cin = 2'b01;
    wide = 2'b10;
    sbq.push_back(model(0, 1'b0, a0, b0, 1'b1));
    sbq.push_back(model(1, 1'b1, a1, b1, 1'b0));
    req = 2'b11;
    seen = 2'b00;
    cnt = 0;
    while (seen != 2'b11 && cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (done[0]) begin seen[0] = 1'b1; req[0] = 1'b0; end
      if (done[1]) begin seen[1] = 1'b1; req[1] = 1'b0; end
    end
    chk("pair_both_done", 64'(seen), 64'd3);
    req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_cout", 64'(result_cout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_add_a", 64'(add_a), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_op(0, 1'b0, 32'h0000_7EED, 32'h0000_3333, 1'b0);
    do_op(1, 1'b1, 32'h1234_8888, 32'h0001_8ABC, 1'b0);
    do_op(0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    do_op(1, 1'b0, 32'h0000_8888, 32'h0000_8ABC, 1'b1);
    pair(32'h0000_1111, 32'h0000_2222, 32'h8000_0000, 32'h8000_0000);
    pair(32'h0000_FFFF, 32'h0000_FFFF, 32'h7FFF_FFFF, 32'h0000_0001);
    do_op(0, 1'b0, 32'h0000_7FFF, 32'h0000_0001, 1'b0);
    do_op(0, 1'b0, 32'h0000_4000, 32'h0000_4000, 1'b0);

    // Wide op on requester 1 (ptr is 1 here), reset while in HIGH.
    @(negedge clk);
    op_a[63:32] = 32'hABCD_8001;
    op_b[63:32] = 32'h1111_8001;
    op_cin[1] = 1'b0;
    wide[1] = 1'b1;
    req[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_high_a", 64'(add_a), 64'hABCD);
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt", 64'(gnt), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    chk("midrst_cout", 64'(result_cout), 64'd0);
    chk("midrst_ovf", 64'(ovf), 64'd0);
    req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pair(32'h0000_0005, 32'h0000_0007, 32'h0000_FFFF, 32'h0000_0001);

    repeat (4) @(negedge clk);
    chk("sb_drain", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
